// File: rtl/syn_sram_acc_pkg.sv
// Shared types and default widths for the synesthesia SRAM access controller.
package syn_sram_acc_pkg;

    localparam int SRAM_DATA_W = 16;
    localparam int SRAM_ADDR_W = 18;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR      = 2'd1,
        WR_HOLD = 2'd2,
        RD      = 2'd3
    } state_t;

endpackage

// File: rtl/syn_sram_acc_modport.sv
// Single-port controller from the SRAM access bus to an asynchronous 16-bit SRAM.
// Optional macro SYN_SRAM_ACC_RD_PIPE_EN adds an input register on sram_dq_i (one extra read cycle).
module syn_sram_acc_modport
    import syn_sram_acc_pkg::*;
#(
    parameter int DATA_W   = SRAM_DATA_W,
    parameter int ADDR_W   = SRAM_ADDR_W,
    parameter int RD_WAIT  = 1,
    parameter int WR_PULSE = 1
) (
    input  logic              clk_ir,
    input  logic              rst_il,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rdy,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dq_o,
    input  logic [DATA_W-1:0] sram_dq_i,
    output logic              sram_dq_oe,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              sram_lb_n,
    output logic              sram_ub_n
);

    logic [DATA_W-1:0] rd_src;

`ifdef SYN_SRAM_ACC_RD_PIPE_EN
    localparam int RD_CYC = RD_WAIT + 1;
    // No reset so the register can be packed into the IO cell.
    always_ff @(posedge clk_ir) rd_src <= sram_dq_i;
`else
    localparam int RD_CYC = RD_WAIT;
    assign rd_src = sram_dq_i;
`endif

    localparam int CNT_MAX = (RD_CYC > WR_PULSE) ? RD_CYC : WR_PULSE;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic              rdy_nx, rd_valid_nx, dq_oe_nx;
    logic              ce_n_nx, oe_n_nx, we_n_nx, lb_n_nx, ub_n_nx;
    logic [DATA_W-1:0] rd_data_nx, dq_o_nx;
    logic [ADDR_W-1:0] addr_nx;

    always_ff @(posedge clk_ir) begin
        if (rst_il) begin
            state      <= IDLE;
            cnt        <= '0;
            rdy        <= 1'b0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            sram_addr  <= '0;
            sram_dq_o  <= '0;
            sram_dq_oe <= 1'b0;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_lb_n  <= 1'b1;
            sram_ub_n  <= 1'b1;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            rdy        <= rdy_nx;
            rd_valid   <= rd_valid_nx;
            rd_data    <= rd_data_nx;
            sram_addr  <= addr_nx;
            sram_dq_o  <= dq_o_nx;
            sram_dq_oe <= dq_oe_nx;
            sram_ce_n  <= ce_n_nx;
            sram_oe_n  <= oe_n_nx;
            sram_we_n  <= we_n_nx;
            sram_lb_n  <= lb_n_nx;
            sram_ub_n  <= ub_n_nx;
        end
    end

    // Next values of every registered output; each output holds unless changed.
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        rdy_nx      = rdy;
        rd_valid_nx = 1'b0;
        rd_data_nx  = rd_data;
        addr_nx     = sram_addr;
        dq_o_nx     = sram_dq_o;
        dq_oe_nx    = sram_dq_oe;
        ce_n_nx     = sram_ce_n;
        oe_n_nx     = sram_oe_n;
        we_n_nx     = sram_we_n;
        lb_n_nx     = sram_lb_n;
        ub_n_nx     = sram_ub_n;
        case (state)
            IDLE: begin
                rdy_nx = 1'b1;
                // rdy gates acceptance so the first cycle out of reset ignores requests.
                if (rdy && wr_en) begin
                    state_nx = WR;
                    cnt_nx   = CNT_W'(WR_PULSE - 1);
                    addr_nx  = addr;
                    dq_o_nx  = wr_data;
                    dq_oe_nx = 1'b1;
                    ce_n_nx  = 1'b0;
                    we_n_nx  = 1'b0;
                    lb_n_nx  = 1'b0;
                    ub_n_nx  = 1'b0;
                    rdy_nx   = 1'b0;
                end else if (rdy && rd_en) begin
                    state_nx = RD;
                    cnt_nx   = CNT_W'(RD_CYC - 1);
                    addr_nx  = addr;
                    ce_n_nx  = 1'b0;
                    oe_n_nx  = 1'b0;
                    lb_n_nx  = 1'b0;
                    ub_n_nx  = 1'b0;
                    rdy_nx   = 1'b0;
                end
            end
            WR: begin
                if (cnt == '0) begin
                    state_nx = WR_HOLD;
                    we_n_nx  = 1'b1;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            WR_HOLD: begin
                state_nx = IDLE;
                dq_oe_nx = 1'b0;
                ce_n_nx  = 1'b1;
                lb_n_nx  = 1'b1;
                ub_n_nx  = 1'b1;
                rdy_nx   = 1'b1;
            end
            RD: begin
                if (cnt == '0) begin
                    state_nx    = IDLE;
                    rd_data_nx  = rd_src;
                    rd_valid_nx = 1'b1;
                    ce_n_nx     = 1'b1;
                    oe_n_nx     = 1'b1;
                    lb_n_nx     = 1'b1;
                    ub_n_nx     = 1'b1;
                    rdy_nx      = 1'b1;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_syn_sram_acc_modport.sv
// Directed bench for syn_sram_acc_modport with a behavioural async SRAM model.
module tb_syn_sram_acc_modport;

`ifdef SYN_SRAM_ACC_RD_PIPE_EN
    localparam int RD_EDGES = 2;
`else
    localparam int RD_EDGES = 1;
`endif

    logic        clk_ir = 1'b0;
    logic        rst_il = 1'b1;
    logic        rd_en = 1'b0, wr_en = 1'b0;
    logic [17:0] addr = '0;
    logic [15:0] wr_data = '0;
    logic        rdy, rd_valid;
    logic [15:0] rd_data;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_o, sram_dq_i;
    logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] mem [0:(1<<18)-1];

    always #5 clk_ir = ~clk_ir;

    syn_sram_acc_modport dut (
        .clk_ir(clk_ir), .rst_il(rst_il), .rd_en(rd_en), .wr_en(wr_en),
        .addr(addr), .wr_data(wr_data), .rdy(rdy), .rd_valid(rd_valid),
        .rd_data(rd_data), .sram_addr(sram_addr), .sram_dq_o(sram_dq_o),
        .sram_dq_i(sram_dq_i), .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n),
        .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .sram_lb_n(sram_lb_n),
        .sram_ub_n(sram_ub_n)
    );

    // Async SRAM: write while ce_n/we_n low with bus driven, read while ce_n/oe_n low.
    always @(posedge clk_ir)
        if (!sram_ce_n && !sram_we_n && sram_dq_oe) mem[sram_addr] <= sram_dq_o;
    assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 16'h0000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_ir);
        @(negedge clk_ir);
    endtask

    task automatic wait_rdy(input string name);
        int k;
        k = 0;
        while (rdy !== 1'b1 && k < 20) begin tick(); k++; end
        chk({name, "_rdy_timeout"}, 32'(rdy), 32'd1);
    endtask

    // Issue one request and watch a fixed window for rd_valid pulses.
    task automatic issue(input string name, input logic r, input logic w, input logic [17:0] a,
                         input logic [15:0] d, input logic exp_v, input logic [15:0] exp_d);
        int pulses, lat;
        logic [15:0] got;
        wait_rdy(name);
        rd_en = r; wr_en = w; addr = a; wr_data = d;
        tick();
        rd_en = 1'b0; wr_en = 1'b0;
        pulses = 0; lat = 0; got = '0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (rd_valid) begin pulses++; lat = k; got = rd_data; end
        end
        chk({name, "_pulses"}, 32'(pulses), exp_v ? 32'd1 : 32'd0);
        if (exp_v) begin
            chk({name, "_latency"}, 32'(lat), 32'(RD_EDGES));
            chk({name, "_data"}, 32'(got), 32'(exp_d));
        end
    endtask

    typedef struct {
        logic        r, w;
        logic [17:0] a;
        logic [15:0] d;
        logic        exp_v;
        logic [15:0] exp_d;
    } vec_t;

    vec_t vecs[$];

    initial begin
        vecs.push_back('{1'b0, 1'b1, 18'h000A5, 16'hBEEF, 1'b0, 16'h0000});
        vecs.push_back('{1'b1, 1'b0, 18'h000A5, 16'h0000, 1'b1, 16'hBEEF});
        vecs.push_back('{1'b1, 1'b1, 18'h3FFFF, 16'h1234, 1'b0, 16'h0000});
        vecs.push_back('{1'b1, 1'b0, 18'h3FFFF, 16'h0000, 1'b1, 16'h1234});
        for (int i = 0; i < 8; i++) begin
            vecs.push_back('{1'b0, 1'b1, 18'(i), 16'hA000 + 16'(i * 16'h0111), 1'b0, 16'h0000});
            vecs.push_back('{1'b1, 1'b0, 18'(i), 16'h0000, 1'b1, 16'hA000 + 16'(i * 16'h0111)});
        end
        vecs.push_back('{1'b1, 1'b0, 18'h000A5, 16'h0000, 1'b1, 16'hBEEF});

        // Reset state
        @(negedge clk_ir);
        tick(); tick();
        chk("rst_rdy", 32'(rdy), 0);
        chk("rst_valid", 32'(rd_valid), 0);
        chk("rst_strobes", {27'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n}, 32'h1F);
        chk("rst_dq_oe", 32'(sram_dq_oe), 0);
        chk("rst_addr", 32'(sram_addr), 0);
        chk("rst_rd_data", 32'(rd_data), 0);
        rst_il = 1'b0;
        tick();
        chk("rst_release_rdy", 32'(rdy), 1);

        // Write strobe sequence
        rd_en = 1'b0; wr_en = 1'b1; addr = 18'h000A5; wr_data = 16'hBEEF;
        tick();
        wr_en = 1'b0;
        chk("wr_addr", 32'(sram_addr), 32'h000A5);
        chk("wr_dq", 32'(sram_dq_o), 32'hBEEF);
        chk("wr_strobes", {26'd0, sram_dq_oe, sram_ce_n, sram_we_n, sram_lb_n, sram_ub_n, rdy}, 32'b100000);
        tick();
        chk("wr_hold", {26'd0, sram_dq_oe, sram_ce_n, sram_we_n, sram_lb_n, sram_ub_n, rdy}, 32'b101000);
        chk("wr_hold_dq", 32'(sram_dq_o), 32'hBEEF);
        tick();
        chk("wr_done", {26'd0, sram_dq_oe, sram_ce_n, sram_we_n, sram_lb_n, sram_ub_n, rdy}, 32'b011111);

        // Table-driven vectors
        foreach (vecs[i])
            issue($sformatf("vec%0d", i), vecs[i].r, vecs[i].w, vecs[i].a, vecs[i].d,
                  vecs[i].exp_v, vecs[i].exp_d);

        // Read held while busy must wait for rdy
        wr_en = 1'b1; addr = 18'h00010; wr_data = 16'h5A5A;
        tick();
        wr_en = 1'b0; rd_en = 1'b1; addr = 18'h00010;
        chk("busy_rdy_low", 32'(rdy), 0);
        tick();
        chk("busy_ignored1", 32'(sram_oe_n), 1);
        tick();
        chk("busy_ignored2", {30'd0, sram_oe_n, rdy}, 32'b11);
        tick();
        chk("busy_accepted", {30'd0, sram_oe_n, rdy}, 32'b00);
        rd_en = 1'b0;
        for (int k = 1; k < RD_EDGES; k++) tick();
        tick();
        chk("busy_valid", {15'd0, rd_valid, rd_data}, {15'd0, 1'b1, 16'h5A5A});

        // Back-to-back: new request accepted while rd_valid is high
        rd_en = 1'b1; addr = 18'h00003;
        chk("b2b_rdy_with_valid", {30'd0, rdy, rd_valid}, 32'b11);
        tick();
        rd_en = 1'b0;
        chk("b2b_accepted", {30'd0, sram_oe_n, rd_valid}, 32'b00);
        for (int k = 1; k < RD_EDGES; k++) tick();
        tick();
        chk("b2b_data", {15'd0, rd_valid, rd_data}, {15'd0, 1'b1, 16'hA333});

        // Reset during write pulse
        tick();
        wr_en = 1'b1; addr = 18'h00020; wr_data = 16'hDEAD;
        tick();
        wr_en = 1'b0;
        chk("mrst_we_low", 32'(sram_we_n), 0);
        rst_il = 1'b1;
        tick();
        chk("mrst_wr_abort", {29'd0, sram_we_n, sram_dq_oe, sram_ce_n}, 32'b101);
        rst_il = 1'b0;
        tick();

        // Reset during read: no rd_valid may appear
        rd_en = 1'b1; addr = 18'h000A5;
        tick();
        rd_en = 1'b0;
        chk("mrst_rd_oe_low", 32'(sram_oe_n), 0);
        rst_il = 1'b1;
        tick();
        chk("mrst_rd_valid", 32'(rd_valid), 0);
        rst_il = 1'b0;
        tick();
        chk("mrst_rd_quiet", {30'd0, rd_valid, sram_oe_n}, 32'b01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
